// File: rtl/button_event_arbiter_pkg.sv
// Shared types and width helpers for the button event arbiter.
// Holds the per-channel state enum and the derived-width functions.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } chan_state_e;

    // Width of a button index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width sized by the longer of the two repeat intervals.
    function automatic int cnt_width(input int d, input int p);
        int m;
        m = (d > p) ? d : p;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Key-event stream between the arbiter (master) and its consumer (slave).
// Ports: o_Valid, o_Id, o_Repeat from master; i_Ready from slave.
interface button_event_if
    import button_event_pkg::*;
#(
    parameter int NUM_BUTTONS = 4
);
    localparam int ID_WIDTH = id_width(NUM_BUTTONS);

    logic                o_Valid;
    logic                i_Ready;
    logic [ID_WIDTH-1:0] o_Id;
    logic                o_Repeat;

    modport master (
        output o_Valid,
        output o_Id,
        output o_Repeat,
        input  i_Ready
    );

    modport slave (
        input  o_Valid,
        input  o_Id,
        input  o_Repeat,
        output i_Ready
    );

endinterface

// File: rtl/button_event_arbiter_channel.sv
// One button channel: edge detect, press/delay/repeat FSM, single pending slot.
// Ports: clk, rst, button_i, grant_i -> pending_o, repeat_o, drop_o.
module button_repeat_channel
    import button_event_pkg::*;
#(
    parameter int REPEAT_DELAY_CYCLES  = 8,
    parameter int REPEAT_PERIOD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic button_i,
    input  logic grant_i,
    output logic pending_o,
    output logic repeat_o,
    output logic drop_o
);
    localparam int CW = cnt_width(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
    localparam logic [CW-1:0] DelayLast  = CW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] PeriodLast = CW'(REPEAT_PERIOD_CYCLES - 1);

    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q;
    logic          pend_q, pend_d;
    logic          rep_q, rep_d;
    logic          press;
    logic          ev;
    logic          ev_rep;

    assign press = button_i & ~prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ev      = 1'b0;
        ev_rep  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    ev      = 1'b1;
                    cnt_d   = '0;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (!button_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == DelayLast) begin
                    ev      = 1'b1;
                    ev_rep  = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!button_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == PeriodLast) begin
                    ev     = 1'b1;
                    ev_rep = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A grant frees the slot on this edge, so a new event then wins
    // instead of being dropped.
    always_comb begin
        pend_d = pend_q & ~grant_i;
        rep_d  = rep_q;
        drop_o = 1'b0;
        if (ev) begin
            if (pend_d) begin
                drop_o = 1'b1;
            end else begin
                pend_d = 1'b1;
                rep_d  = ev_rep;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            pend_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= button_i;
            pend_q  <= pend_d;
            rep_q   <= rep_d;
        end
    end

    assign pending_o = pend_q;
    assign repeat_o  = rep_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Round-robin merge of per-button key events into one valid/ready stream.
// Ports: i_Clk, i_Reset, i_Buttons, evt (master), o_Overrun.
module button_event_arbiter
    import button_event_pkg::*;
#(
    parameter int NUM_BUTTONS          = 4,
    parameter int REPEAT_DELAY_CYCLES  = 8,
    parameter int REPEAT_PERIOD_CYCLES = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic [NUM_BUTTONS-1:0] i_Buttons,
    button_event_if.master         evt,
    output logic                   o_Overrun
);
    localparam int ID_WIDTH = id_width(NUM_BUTTONS);

    logic [NUM_BUTTONS-1:0] pend;
    logic [NUM_BUTTONS-1:0] rep;
    logic [NUM_BUTTONS-1:0] drop;
    logic [NUM_BUTTONS-1:0] grant;

    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [ID_WIDTH-1:0] gidx;
    logic                valid_q, valid_d;
    logic                rpt_q, rpt_d;
    logic                ovr_q, ovr_d;
    logic                found;
    logic                load;

    for (genvar j = 0; j < NUM_BUTTONS; j++) begin : g_chan
        button_repeat_channel #(
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
        ) u_chan (
            .clk      (i_Clk),
            .rst      (i_Reset),
            .button_i (i_Buttons[j]),
            .grant_i  (grant[j]),
            .pending_o(pend[j]),
            .repeat_o (rep[j]),
            .drop_o   (drop[j])
        );
    end

    // Output slot refills when empty or being drained this edge.
    assign load = ~valid_q | evt.i_Ready;

    // First pending channel at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gidx  = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_BUTTONS) idx = idx - NUM_BUTTONS;
            if (!found && pend[idx]) begin
                found = 1'b1;
                gidx  = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        rpt_d   = rpt_q;
        ptr_d   = ptr_q;
        grant   = '0;
        if (load) begin
            valid_d = found;
            if (found) begin
                id_d        = gidx;
                rpt_d       = rep[gidx];
                grant[gidx] = 1'b1;
                if (int'(gidx) == NUM_BUTTONS - 1) ptr_d = '0;
                else ptr_d = gidx + 1'b1;
            end
        end
        ovr_d = |drop;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            rpt_q   <= 1'b0;
            ptr_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            rpt_q   <= rpt_d;
            ptr_q   <= ptr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign evt.o_Valid  = valid_q;
    assign evt.o_Id     = id_q;
    assign evt.o_Repeat = rpt_q;
    assign o_Overrun    = ovr_q;

endmodule
